axis_frame_arb: RTL and testbench

Frame-aware round-robin arbiter that shares one AXI-Stream FIFO write port among S_COUNT source streams. It grants one source at a time and holds the grant until that source's tlast beat is accepted, so frames never interleave in the shared `axis_fifo`. The source index is forwarded on `m_axis_tid`. It sits directly in front of the FIFO's `s_axis` port; its output drives that port, and that port's `tready` drives `m_axis_tready`.

---
 rtl/axis_arb_pkg.sv | 20 ++
 rtl/rr_select.sv | 35 +++
 rtl/axis_frame_arb.sv | 140 ++++++++++++++
 tb/tb_axis_frame_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for AXI-Stream arbiters.
// Holds the arbiter state encoding and packed-bus slicing helpers.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    // LSB position of port idx inside a packed per-port bus.
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    // Round-robin start point: one past the previous winner, wrapping.
    function automatic int rr_start(input int last, input int n);
        return (last + 1) % n;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector.
// Rotates the request vector to the start point, then priority-encodes.
module rr_select
    import axis_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         any_req,
    output logic [W-1:0] sel
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             start;
    int             hit;

    // Rotate so the preferred requester sits at bit 0, then take lowest set bit.
    always_comb begin
        start   = rr_start(int'(last), N);
        dbl     = {req, req} >> start;
        rot     = dbl[N-1:0];
        hit     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = i;
            end
        end
        any_req = |req;
        sel     = W'((start + hit) % N);
    end

endmodule

// File: rtl/axis_frame_arb.sv
// Frame-aware round-robin arbiter in front of a shared AXI-Stream FIFO.
// A grant is held until the granted source's tlast beat is accepted.
module axis_frame_arb
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int SEL_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [SEL_WIDTH-1:0]          m_axis_tid,
    output logic                          grant_valid,
    output logic [SEL_WIDTH-1:0]          grant_index
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [SEL_WIDTH-1:0]  grant_q;
    logic [SEL_WIDTH-1:0]  last_grant;
    logic                  any_req;
    logic [SEL_WIDTH-1:0]  sel;
    logic                  out_free;
    logic                  cur_valid;
    logic                  cur_last;
    logic                  accept;
    logic                  arb_win;

    logic [DATA_WIDTH-1:0] data_q;
    logic [KEEP_WIDTH-1:0] keep_q;
    logic                  valid_q;
    logic                  last_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [SEL_WIDTH-1:0]  tid_q;

    rr_select #(
        .N (S_COUNT),
        .W (SEL_WIDTH)
    ) u_rr (
        .req     (s_axis_tvalid),
        .last    (last_grant),
        .any_req (any_req),
        .sel     (sel)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign out_free  = m_axis_tready || !valid_q;
    assign cur_valid = s_axis_tvalid[grant_q];
    assign cur_last  = s_axis_tlast[grant_q];

    // Next-state logic and tready steering toward the granted source.
    always_comb begin
        state_d       = state_q;
        s_axis_tready = '0;
        accept        = 1'b0;
        arb_win       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    arb_win = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                s_axis_tready[grant_q] = out_free;
                accept = cur_valid && out_free;
                if (accept && cur_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping; last_grant starts at the top so source 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q    <= '0;
            last_grant <= SEL_WIDTH'(S_COUNT - 1);
        end else if (arb_win) begin
            grant_q    <= sel;
            last_grant <= sel;
        end
    end

    // Output valid: set on accept, cleared once downstream takes the beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
        end else if (m_axis_tready) begin
            valid_q <= 1'b0;
        end
    end

    // Output payload register, loaded only on an accepted source beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= s_axis_tdata[field_lsb(int'(grant_q), DATA_WIDTH) +: DATA_WIDTH];
            keep_q <= s_axis_tkeep[field_lsb(int'(grant_q), KEEP_WIDTH) +: KEEP_WIDTH];
            user_q <= s_axis_tuser[field_lsb(int'(grant_q), USER_WIDTH) +: USER_WIDTH];
            last_q <= cur_last;
            tid_q  <= grant_q;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = KEEP_ENABLE ? keep_q : {KEEP_WIDTH{1'b1}};
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tid    = tid_q;
    assign grant_valid   = (state_q == ACTIVE);
    assign grant_index   = grant_q;

endmodule

// File: tb/tb_axis_frame_arb.sv
// Scoreboard bench for axis_frame_arb.
// Expected beats are queued up front; a monitor pops them as beats leave.
module tb_axis_frame_arb;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 1;
    localparam int SW = 2;

    typedef struct {
        int         tid;
        logic [7:0] data;
        logic       last;
        int         dly;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [S*DW-1:0] s_axis_tdata;
    logic [S*KW-1:0] s_axis_tkeep;
    logic [S-1:0]    s_axis_tvalid;
    logic [S-1:0]    s_axis_tready;
    logic [S-1:0]    s_axis_tlast;
    logic [S*UW-1:0] s_axis_tuser;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast;
    logic [UW-1:0]   m_axis_tuser;
    logic [SW-1:0]   m_axis_tid;
    logic            grant_valid;
    logic [SW-1:0]   grant_index;

    logic [7:0] dat [S];
    logic       vld [S];
    logic       lst [S];

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    axis_frame_arb #(
        .S_COUNT    (S),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tid    (m_axis_tid),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index)
    );

    always #5 clk = ~clk;

    always_comb begin
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        s_axis_tkeep  = '1;
        for (int i = 0; i < S; i++) begin
            s_axis_tdata[i*DW +: DW] = dat[i];
            s_axis_tvalid[i]         = vld[i];
            s_axis_tlast[i]          = lst[i];
            s_axis_tuser[i]          = dat[i][0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int s, input logic [7:0] d0, input int n,
                              input int first_dly, input int rest_dly);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tid  = s;
            e.data = d0 + 8'(k * 17);
            e.last = (k == n - 1);
            e.dly  = (k == 0) ? first_dly : rest_dly;
            q.push_back(e);
        end
    endtask

    // Present one beat from source s; returns on the negedge after acceptance.
    task automatic beat(input int s, input logic [7:0] d, input logic l);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        vld[s] = 1'b1;
        dat[s] = d;
        lst[s] = l;
        while (!acc && n < 100) begin
            #4;
            acc = s_axis_tready[s];
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_src%0d", s), 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input int s, input logic [7:0] d0, input int n,
                              input int stall_after, input int stall_len);
        logic [S-1:0] others;
        for (int k = 0; k < n; k++) begin
            beat(s, d0 + 8'(k * 17), (k == n - 1));
            if (k == stall_after) begin
                vld[s] = 1'b0;
                repeat (stall_len) begin
                    #4;
                    others = s_axis_tready & ~(S'(1) << s);
                    chk("stall_grant_valid", 32'(grant_valid), 32'd1);
                    chk("stall_grant_index", 32'(grant_index), 32'(s));
                    chk("stall_others_ready", 32'(others), 32'd0);
                    @(negedge clk);
                end
            end
        end
        vld[s] = 1'b0;
        lst[s] = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a beat transfers downstream.
    initial begin
        exp_t e;
        int   cyc;
        int   last_cyc;
        cyc      = 0;
        last_cyc = -100;
        forever begin
            @(negedge clk);
            cyc++;
            #4;
            if (rst_n && m_axis_tvalid && m_axis_tready) begin
                chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("tid", 32'(m_axis_tid), 32'(e.tid));
                    chk("tdata", 32'(m_axis_tdata), 32'(e.data));
                    chk("tlast", 32'(m_axis_tlast), 32'(e.last));
                    chk("tuser", 32'(m_axis_tuser), 32'(e.data[0]));
                    chk("tkeep", 32'(m_axis_tkeep), 32'd1);
                    if (e.dly >= 0) begin
                        chk("beat_spacing", 32'(cyc - last_cyc), 32'(e.dly));
                    end
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < S; i++) begin
            vld[i] = 1'b1;
            dat[i] = 8'h11;
            lst[i] = 1'b0;
        end

        // Reset with every source requesting.
        @(negedge clk);
        chk("rst_s_ready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        @(negedge clk);
        chk("rst_s_ready2", 32'(s_axis_tready), 32'd0);
        chk("rst_m_valid2", 32'(m_axis_tvalid), 32'd0);
        chk("rst_grant_index", 32'(grant_index), 32'd0);
        push_frame(0, 8'h11, 3, -1, 1);
        rst_n = 1'b1;
        for (int i = 1; i < S; i++) vld[i] = 1'b0;
        @(negedge clk);
        chk("first_grant_valid", 32'(grant_valid), 32'd1);
        chk("first_grant_index", 32'(grant_index), 32'd0);
        send_frame(0, 8'h11, 3, -1, 0);
        repeat (4) @(negedge clk);

        // Fairness: last winner was 0, so order is 1,2,3,0 twice.
        push_frame(1, 8'h40, 2, -1, 1);
        push_frame(2, 8'h50, 2, 2, 1);
        push_frame(3, 8'h60, 2, 2, 1);
        push_frame(0, 8'h70, 2, 2, 1);
        push_frame(1, 8'h48, 2, 2, 1);
        push_frame(2, 8'h58, 2, 2, 1);
        push_frame(3, 8'h68, 2, 2, 1);
        push_frame(0, 8'h78, 2, 2, 1);
        fork
            begin
                send_frame(0, 8'h70, 2, -1, 0);
                send_frame(0, 8'h78, 2, -1, 0);
            end
            begin
                send_frame(1, 8'h40, 2, -1, 0);
                send_frame(1, 8'h48, 2, -1, 0);
            end
            begin
                send_frame(2, 8'h50, 2, -1, 0);
                send_frame(2, 8'h58, 2, -1, 0);
            end
            begin
                send_frame(3, 8'h60, 2, -1, 0);
                send_frame(3, 8'h68, 2, -1, 0);
            end
        join
        repeat (4) @(negedge clk);

        // Backpressure: downstream ready toggles during a 5-beat frame.
        push_frame(2, 8'h80, 5, -1, -1);
        fork
            send_frame(2, 8'h80, 5, -1, 0);
            begin
                for (int i = 0; i < 16; i++) begin
                    m_axis_tready = (i % 2 == 0);
                    @(negedge clk);
                end
                m_axis_tready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        // Mid-frame stall by source 1 while source 3 waits.
        push_frame(1, 8'hC0, 4, -1, -1);
        push_frame(3, 8'hD0, 2, 2, 1);
        fork
            send_frame(1, 8'hC0, 4, 1, 4);
            begin
                repeat (3) @(negedge clk);
                send_frame(3, 8'hD0, 2, -1, 0);
            end
        join
        repeat (4) @(negedge clk);

        // Wrap: last winner 3, requests {0,2} -> 0 then 2.
        push_frame(0, 8'hE0, 2, -1, 1);
        push_frame(2, 8'hF0, 2, 2, 1);
        fork
            send_frame(0, 8'hE0, 2, -1, 0);
            send_frame(2, 8'hF0, 2, -1, 0);
        join
        repeat (4) @(negedge clk);

        // Reset mid-frame: second beat sits in the output register.
        push_frame(2, 8'hA0, 1, -1, -1);
        q[q.size() - 1].last = 1'b0;
        beat(2, 8'hA0, 1'b0);
        beat(2, 8'hB1, 1'b0);
        rst_n = 1'b0;
        m_axis_tready = 1'b0;
        dat[2] = 8'hC2;
        @(negedge clk);
        chk("mid_rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_s_ready", 32'(s_axis_tready), 32'd0);
        chk("mid_rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("mid_rst_grant_index", 32'(grant_index), 32'd0);
        rst_n = 1'b1;
        vld[2] = 1'b0;
        m_axis_tready = 1'b1;
        // After reset the search restarts at 0, so 1 beats 3.
        push_frame(1, 8'h20, 2, -1, 1);
        push_frame(3, 8'h30, 2, 2, 1);
        fork
            send_frame(1, 8'h20, 2, -1, 0);
            send_frame(3, 8'h30, 2, -1, 0);
        join
        repeat (10) @(negedge clk);
        chk("sb_drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
